z80_sound_latch: RTL and testbench
==================================

// Module: z80_sound_latch
// PURPOSE
//  68k<->Z80 sound-command mailbox sitting between the 68k bus decode and the Z80 side of the
//  I/O controller. Consumes the Z80 port strobes nSDZ80R/nSDZ80W/nSDZ80CLR, buffers 68k
//  sound commands in a small FIFO, holds the Z80 reply byte, and raises the NMI request
//  that the Z80 controller forwards as nZ80NMI. Fully synchronous to CLK; strobes are edge-detected.
// PARAMETERS
//  CMD_DEPTH   2      command FIFO entries; legal values 1, 2, 4
//  EMPTY_BYTE  8'hFF  SDD_OUT value when Z80 reads with FIFO empty and no command ever popped
// PORTS
//  CLK            in   1  system clock
//  RESET          in   1  synchronous reset, active-high
//  nSOUND_WR      in   1  68k sound-command write strobe, active low, synchronous to CLK
//  nSOUND_RD      in   1  68k sound-reply read strobe, active low
//  M68K_DATA_IN   in   8  68k write data, valid while nSOUND_WR low
//  M68K_DATA_OUT  out  8  reply byte presented to 68k
//  nSDZ80R        in   1  Z80 command-port read strobe, active low
//  nSDZ80W        in   1  Z80 reply-port write strobe, active low
//  nSDZ80CLR      in   1  Z80 NMI/overrun clear strobe, active low
//  SDD_IN         in   8  Z80 write data, valid while nSDZ80W low
//  SDD_OUT        out  8  command byte presented to Z80
//  SDD_OE         out  1  high while nSDZ80R low (combinational)
//  NMI_EN         in   1  NMI enable from Z80 controller
//  nZ80NMI_REQ    out  1  registered NMI request, active low
//  CMD_PENDING    out  1  FIFO non-empty
//  REPLY_VALID    out  1  reply written by Z80, not yet read by 68k
//  OVERRUN        out  1  sticky: 68k pushed while FIFO full
// BEHAVIOUR
//  - Each strobe registered once per CLK; "release" = registered value 0 and current input 1.
//    State updates on that same CLK edge; outputs reflect it from the next cycle.
//  - Data capture: holding reg loads M68K_DATA_IN (resp. SDD_IN) every cycle its strobe is low;
//    commit on release uses the value from the last low cycle.
//  - Command push on nSOUND_WR release: write at tail. FIFO full -> overwrite newest entry,
//    count unchanged, OVERRUN<=1.
//  - Command pop on nSDZ80R release when non-empty: head advances, last_cmd<=popped byte.
//    Release while empty: no state change.
//  - SDD_OUT = non-empty ? fifo[head] : last_cmd; last_cmd resets to EMPTY_BYTE.
//  - Push and pop on same edge: non-empty -> both occur, count unchanged; empty -> push only.
//  - Pointers wrap modulo CMD_DEPTH; count width clog2(CMD_DEPTH)+1; CMD_PENDING = (count!=0).
//  - nmi_flag: set on every push, cleared on nSDZ80CLR release; same-edge push+clear -> set wins.
//    nSDZ80CLR release also clears OVERRUN (same-edge overflow push -> OVERRUN stays 1).
//  - nZ80NMI_REQ <= ~(nmi_flag & NMI_EN), registered: low one cycle after flag set with NMI_EN=1.
//    NMI_EN 0->1 with flag set asserts next cycle; NMI_EN low masks but does not clear flag.
//  - Reply: nSDZ80W release -> reply<=captured byte, REPLY_VALID<=1. nSOUND_RD release ->
//    REPLY_VALID<=0. Same edge -> new byte stored, REPLY_VALID=1. M68K_DATA_OUT = reply always.
//  - RESET (any cycle, incl. mid-strobe): count/pointers 0, last_cmd=EMPTY_BYTE, reply=8'h00,
//    REPLY_VALID=0, OVERRUN=0, nmi_flag=0, nZ80NMI_REQ=1, strobe regs=1 (no release
//    detected on the first cycle after RESET even if a strobe is low).
//  - Reset outputs: SDD_OUT=EMPTY_BYTE, M68K_DATA_OUT=8'h00, CMD_PENDING=0, REPLY_VALID=0,
//    OVERRUN=0, nZ80NMI_REQ=1; SDD_OE follows nSDZ80R.
// TESTING
//  1 NMI_EN=1, 68k writes 8'h3A -> CMD_PENDING=1, SDD_OUT=8'h3A, nZ80NMI_REQ low next cycle;
//    nSDZ80R pulse -> CMD_PENDING=0; nSDZ80CLR pulse -> nZ80NMI_REQ=1.
//  2 DEPTH=2: write 01,02,03 -> OVERRUN=1, reads return 01 then 03, third read returns 03.
//  3 Write 8'h55 on same edge as pop of 8'h11 (count=1) -> count=1, SDD_OUT=8'h55.
//  4 Z80 writes 8'hC3 -> REPLY_VALID=1, M68K_DATA_OUT=8'hC3; 68k read -> REPLY_VALID=0;
//    simultaneous Z80 write 8'h7E + 68k read -> REPLY_VALID=1, M68K_DATA_OUT=8'h7E.
//  5 NMI_EN=0, push -> nZ80NMI_REQ stays 1; raise NMI_EN -> low next cycle.
//  6 RESET asserted with nSOUND_WR low and FIFO full -> all outputs at reset values;
//    strobe released after RESET -> exactly one push.

Source files
------------

// File: rtl/z80_sound_latch.sv
// rtl/z80_sound_latch.sv - 68k<->Z80 sound-command mailbox: command FIFO, reply byte, NMI request.
module z80_sound_latch #(
  parameter int         CMD_DEPTH  = 2,
  parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       nSOUND_WR,
  input  logic       nSOUND_RD,
  input  logic [7:0] M68K_DATA_IN,
  output logic [7:0] M68K_DATA_OUT,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_OUT,
  output logic       SDD_OE,
  input  logic       NMI_EN,
  output logic       nZ80NMI_REQ,
  output logic       CMD_PENDING,
  output logic       REPLY_VALID,
  output logic       OVERRUN
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  logic          wr_q, rd_q, z80r_q, z80w_q, clr_q;
  logic [7:0]    cmd_hold, rep_hold;
  logic [7:0]    fifo [CMD_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [7:0]    last_cmd, reply;
  logic          nmi_flag;

  logic          wr_rel, rd_rel, z80r_rel, z80w_rel, clr_rel;
  logic          non_empty, full, pop_ok, overflow;
  logic [PW-1:0] newest;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A release is the rising edge of an active-low strobe as seen by the sampling register.
  assign wr_rel   = ~wr_q   & nSOUND_WR;
  assign rd_rel   = ~rd_q   & nSOUND_RD;
  assign z80r_rel = ~z80r_q & nSDZ80R;
  assign z80w_rel = ~z80w_q & nSDZ80W;
  assign clr_rel  = ~clr_q  & nSDZ80CLR;

  assign non_empty = (count != '0);
  assign full      = (count == CW'(CMD_DEPTH));
  assign pop_ok    = z80r_rel & non_empty;
  // A pop on the same edge frees a slot, so only a push without pop can overflow.
  assign overflow  = wr_rel & full & ~pop_ok;
  assign newest    = (tail == '0) ? PW'(CMD_DEPTH - 1) : tail - 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      z80r_q      <= 1'b1;
      z80w_q      <= 1'b1;
      clr_q       <= 1'b1;
      cmd_hold    <= 8'h00;
      rep_hold    <= 8'h00;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_cmd    <= EMPTY_BYTE;
      reply       <= 8'h00;
      REPLY_VALID <= 1'b0;
      OVERRUN     <= 1'b0;
      nmi_flag    <= 1'b0;
      nZ80NMI_REQ <= 1'b1;
    end else begin
      wr_q   <= nSOUND_WR;
      rd_q   <= nSOUND_RD;
      z80r_q <= nSDZ80R;
      z80w_q <= nSDZ80W;
      clr_q  <= nSDZ80CLR;
      if (!nSOUND_WR) cmd_hold <= M68K_DATA_IN;
      if (!nSDZ80W)   rep_hold <= SDD_IN;

      if (wr_rel) begin
        if (overflow) fifo[newest] <= cmd_hold;
        else begin
          fifo[tail] <= cmd_hold;
          tail       <= ptr_inc(tail);
        end
      end
      if (pop_ok) begin
        head     <= ptr_inc(head);
        last_cmd <= fifo[head];
      end
      if (wr_rel && !overflow && !pop_ok) count <= count + 1'b1;
      else if (pop_ok && !wr_rel)         count <= count - 1'b1;

      if (wr_rel)       nmi_flag <= 1'b1;
      else if (clr_rel) nmi_flag <= 1'b0;

      if (overflow)     OVERRUN <= 1'b1;
      else if (clr_rel) OVERRUN <= 1'b0;

      nZ80NMI_REQ <= ~(nmi_flag & NMI_EN);

      if (z80w_rel) begin
        reply       <= rep_hold;
        REPLY_VALID <= 1'b1;
      end else if (rd_rel) begin
        REPLY_VALID <= 1'b0;
      end
    end
  end

  assign SDD_OUT       = non_empty ? fifo[head] : last_cmd;
  assign SDD_OE        = ~nSDZ80R;
  assign M68K_DATA_OUT = reply;
  assign CMD_PENDING   = non_empty;

endmodule

// File: tb/tb_z80_sound_latch.sv
// tb/tb_z80_sound_latch.sv - directed self-checking bench for z80_sound_latch.
module tb_z80_sound_latch;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       nSOUND_WR = 1'b1, nSOUND_RD = 1'b1;
  logic [7:0] M68K_DATA_IN = 8'h00, M68K_DATA_OUT;
  logic       nSDZ80R = 1'b1, nSDZ80W = 1'b1, nSDZ80CLR = 1'b1;
  logic [7:0] SDD_IN = 8'h00, SDD_OUT;
  logic       SDD_OE, NMI_EN = 1'b1, nZ80NMI_REQ, CMD_PENDING, REPLY_VALID, OVERRUN;

  int total = 0;
  int bad = 0;

  z80_sound_latch #(.CMD_DEPTH(2), .EMPTY_BYTE(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET),
    .nSOUND_WR(nSOUND_WR), .nSOUND_RD(nSOUND_RD),
    .M68K_DATA_IN(M68K_DATA_IN), .M68K_DATA_OUT(M68K_DATA_OUT),
    .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W), .nSDZ80CLR(nSDZ80CLR),
    .SDD_IN(SDD_IN), .SDD_OUT(SDD_OUT), .SDD_OE(SDD_OE),
    .NMI_EN(NMI_EN), .nZ80NMI_REQ(nZ80NMI_REQ),
    .CMD_PENDING(CMD_PENDING), .REPLY_VALID(REPLY_VALID), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr68(input logic [7:0] d);
    M68K_DATA_IN = d; nSOUND_WR = 1'b0; cyc(1);
    nSOUND_WR = 1'b1; cyc(1);
  endtask

  task automatic rd68();
    nSOUND_RD = 1'b0; cyc(1);
    nSOUND_RD = 1'b1; cyc(1);
  endtask

  task automatic z80rd();
    nSDZ80R = 1'b0; #1 chk("sdd_oe_low", SDD_OE, 1);
    cyc(1);
    nSDZ80R = 1'b1; cyc(1);
  endtask

  task automatic z80wr(input logic [7:0] d);
    SDD_IN = d; nSDZ80W = 1'b0; cyc(1);
    nSDZ80W = 1'b1; cyc(1);
  endtask

  task automatic z80clr();
    nSDZ80CLR = 1'b0; cyc(1);
    nSDZ80CLR = 1'b1; cyc(1);
  endtask

  initial begin
    cyc(2);
    RESET = 1'b0;
    cyc(1);
    chk("rst_sdd_out", SDD_OUT, 8'hFF);
    chk("rst_m68k_out", M68K_DATA_OUT, 8'h00);
    chk("rst_pending", CMD_PENDING, 0);
    chk("rst_reply_valid", REPLY_VALID, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_nmi", nZ80NMI_REQ, 1);
    chk("rst_sdd_oe", SDD_OE, 0);

    // basic command path and NMI
    wr68(8'h3A);
    chk("t1_pending", CMD_PENDING, 1);
    chk("t1_sdd_out", SDD_OUT, 8'h3A);
    chk("t1_nmi_not_yet", nZ80NMI_REQ, 1);
    cyc(1);
    chk("t1_nmi_low", nZ80NMI_REQ, 0);
    z80rd();
    chk("t1_pending_after_rd", CMD_PENDING, 0);
    chk("t1_last_cmd", SDD_OUT, 8'h3A);
    z80clr();
    cyc(1);
    chk("t1_nmi_cleared", nZ80NMI_REQ, 1);

    // overflow on a two-entry FIFO
    wr68(8'h01);
    wr68(8'h02);
    chk("t2_no_overrun", OVERRUN, 0);
    wr68(8'h03);
    chk("t2_overrun", OVERRUN, 1);
    chk("t2_head0", SDD_OUT, 8'h01);
    z80rd();
    chk("t2_head1", SDD_OUT, 8'h03);
    chk("t2_pending1", CMD_PENDING, 1);
    z80rd();
    chk("t2_empty", CMD_PENDING, 0);
    chk("t2_last", SDD_OUT, 8'h03);
    z80rd();
    chk("t2_third_rd", SDD_OUT, 8'h03);
    chk("t2_third_pending", CMD_PENDING, 0);
    z80clr();
    chk("t2_overrun_clr", OVERRUN, 0);

    // simultaneous push and pop, non-empty then empty
    wr68(8'h11);
    M68K_DATA_IN = 8'h55; nSOUND_WR = 1'b0; nSDZ80R = 1'b0; cyc(1);
    nSOUND_WR = 1'b1; nSDZ80R = 1'b1; cyc(1);
    chk("t3_pending", CMD_PENDING, 1);
    chk("t3_sdd_out", SDD_OUT, 8'h55);
    z80rd();
    chk("t3_drained", CMD_PENDING, 0);
    M68K_DATA_IN = 8'h66; nSOUND_WR = 1'b0; nSDZ80R = 1'b0; cyc(1);
    nSOUND_WR = 1'b1; nSDZ80R = 1'b1; cyc(1);
    chk("t3_empty_push_only", CMD_PENDING, 1);
    chk("t3_empty_sdd_out", SDD_OUT, 8'h66);
    z80rd();
    chk("t3_empty_pop", CMD_PENDING, 0);

    // reply path
    z80wr(8'hC3);
    chk("t4_valid", REPLY_VALID, 1);
    chk("t4_data", M68K_DATA_OUT, 8'hC3);
    rd68();
    chk("t4_read", REPLY_VALID, 0);
    chk("t4_data_kept", M68K_DATA_OUT, 8'hC3);
    SDD_IN = 8'h7E; nSDZ80W = 1'b0; nSOUND_RD = 1'b0; cyc(1);
    nSDZ80W = 1'b1; nSOUND_RD = 1'b1; cyc(1);
    chk("t4_same_valid", REPLY_VALID, 1);
    chk("t4_same_data", M68K_DATA_OUT, 8'h7E);
    SDD_IN = 8'hA1; nSDZ80W = 1'b0; cyc(1);
    SDD_IN = 8'hB2; cyc(1);
    nSDZ80W = 1'b1; SDD_IN = 8'h00; cyc(1);
    chk("t4_last_low_byte", M68K_DATA_OUT, 8'hB2);

    // NMI masking and clear priority
    z80clr();
    NMI_EN = 1'b0;
    wr68(8'h44);
    cyc(2);
    chk("t5_masked", nZ80NMI_REQ, 1);
    NMI_EN = 1'b1;
    cyc(1);
    chk("t5_unmasked", nZ80NMI_REQ, 0);
    z80rd();
    z80clr();
    cyc(1);
    chk("t5_cleared", nZ80NMI_REQ, 1);
    M68K_DATA_IN = 8'h77; nSOUND_WR = 1'b0; nSDZ80CLR = 1'b0; cyc(1);
    nSOUND_WR = 1'b1; nSDZ80CLR = 1'b1; cyc(2);
    chk("t5_set_wins", nZ80NMI_REQ, 0);
    wr68(8'h78);
    M68K_DATA_IN = 8'h79; nSOUND_WR = 1'b0; nSDZ80CLR = 1'b0; cyc(1);
    nSOUND_WR = 1'b1; nSDZ80CLR = 1'b1; cyc(1);
    chk("t5_overrun_set_wins", OVERRUN, 1);

    // reset mid-strobe with FIFO full
    M68K_DATA_IN = 8'h9C; nSOUND_WR = 1'b0; cyc(1);
    RESET = 1'b1; cyc(2);
    chk("t6_pending", CMD_PENDING, 0);
    chk("t6_sdd_out", SDD_OUT, 8'hFF);
    chk("t6_overrun", OVERRUN, 0);
    chk("t6_nmi", nZ80NMI_REQ, 1);
    chk("t6_reply", M68K_DATA_OUT, 8'h00);
    chk("t6_valid", REPLY_VALID, 0);
    RESET = 1'b0; cyc(2);
    chk("t6_no_early_push", CMD_PENDING, 0);
    nSOUND_WR = 1'b1; cyc(1);
    chk("t6_one_push", CMD_PENDING, 1);
    chk("t6_push_data", SDD_OUT, 8'h9C);
    z80rd();
    chk("t6_exactly_one", CMD_PENDING, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
